// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, addresses the instruction ROM
// and latches the returned word into the IF/ID pipeline register.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   stall_if         hold PC, IF/ID and fetch count (load-use hazard)
//   redirect_valid   taken branch/jump from EX; beats stall_if and flushes IF/ID
//   redirect_pc      redirect target (low two bits dropped, flagged if non-zero)
//   im_addr          ROM word address, combinational from pc_out
//   im_instr         ROM read data, combinational from im_addr
//   pc_out           current fetch PC
//   ifid_pc/_pc4     PC (and PC+4) of the instruction held in IF/ID
//   ifid_instr       instruction held in IF/ID (NOP when bubbled)
//   ifid_valid       IF/ID holds a real instruction
//   misalign_exc     one-cycle pulse on a non-word-aligned redirect target
//   fetch_cnt        number of valid instructions latched into IF/ID
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned IM_ADDR_W = 8,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 stall_if,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic [IM_ADDR_W-1:0] im_addr,
  input  logic [31:0]          im_instr,
  output logic [31:0]          pc_out,
  output logic [31:0]          ifid_pc,
  output logic [31:0]          ifid_pc4,
  output logic [31:0]          ifid_instr,
  output logic                 ifid_valid,
  output logic                 misalign_exc,
  output logic [31:0]          fetch_cnt
);

  localparam int unsigned ROM_SHIFT = IM_ADDR_W + 2;

  logic [31:0] pc_plus4;
  logic        in_range;

  // ROM word address and range check; the PC path never looks at im_instr
  assign im_addr  = pc_out[IM_ADDR_W+1:2];
  assign pc_plus4 = pc_out + 32'd4;
  assign in_range = ((pc_out >> ROM_SHIFT) == 32'd0);

  // PC, IF/ID register, exception pulse and fetch counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_out       <= RESET_PC;
      ifid_pc      <= 32'd0;
      ifid_pc4     <= 32'd0;
      ifid_instr   <= NOP_INSTR;
      ifid_valid   <= 1'b0;
      misalign_exc <= 1'b0;
      fetch_cnt    <= 32'd0;
    end else if (redirect_valid) begin
      // Redirect wins over stall; ifid_pc/ifid_pc4 deliberately keep old values
      pc_out       <= {redirect_pc[31:2], 2'b00};
      ifid_instr   <= NOP_INSTR;
      ifid_valid   <= 1'b0;
      misalign_exc <= (redirect_pc[1:0] != 2'b00);
    end else if (stall_if) begin
      misalign_exc <= 1'b0;
    end else begin
      pc_out       <= pc_plus4;
      ifid_pc      <= pc_out;
      ifid_pc4     <= pc_plus4;
      misalign_exc <= 1'b0;
      if (in_range) begin
        ifid_instr <= im_instr;
        ifid_valid <= 1'b1;
        fetch_cnt  <= fetch_cnt + 32'd1;
      end else begin
        ifid_instr <= NOP_INSTR;
        ifid_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a behavioural combinational ROM.
module tb_if_stage;

  localparam int unsigned IM_ADDR_W = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic                 clk;
  logic                 rstn;
  logic                 stall_if;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
  logic [IM_ADDR_W-1:0] im_addr;
  logic [31:0]          im_instr;
  logic [31:0]          pc_out;
  logic [31:0]          ifid_pc;
  logic [31:0]          ifid_pc4;
  logic [31:0]          ifid_instr;
  logic                 ifid_valid;
  logic                 misalign_exc;
  logic [31:0]          fetch_cnt;

  logic [31:0] rom [0:(1<<IM_ADDR_W)-1];

  int n_vec;
  int n_bad;

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .IM_ADDR_W(IM_ADDR_W),
    .NOP_INSTR(NOP)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .stall_if      (stall_if),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .im_addr       (im_addr),
    .im_instr      (im_instr),
    .pc_out        (pc_out),
    .ifid_pc       (ifid_pc),
    .ifid_pc4      (ifid_pc4),
    .ifid_instr    (ifid_instr),
    .ifid_valid    (ifid_valid),
    .misalign_exc  (misalign_exc),
    .fetch_cnt     (fetch_cnt)
  );

  assign im_instr = rom[im_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    step();
    rstn = 1'b1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                             input logic [31:0] ins, input logic vld, input logic [31:0] cnt);
    check({tag, ".pc"},    pc_out,            pc);
    check({tag, ".ipc"},   ifid_pc,           ipc);
    check({tag, ".ipc4"},  ifid_pc4,          ipc + 32'd4);
    check({tag, ".instr"}, ifid_instr,        ins);
    check({tag, ".valid"}, 32'(ifid_valid),   32'(vld));
    check({tag, ".cnt"},   fetch_cnt,         cnt);
  endtask

  logic [31:0] seq_instr [0:3];

  initial begin
    n_vec = 0;
    n_bad = 0;
    for (int i = 0; i < (1 << IM_ADDR_W); i++) rom[i] = 32'hA500_0000 | 32'(i);
    rom[0] = 32'h0050_0093;
    rom[1] = 32'h0030_0113;
    rom[2] = 32'h0020_81B3;
    rom[3] = 32'h0000_0013;
    for (int i = 0; i < 4; i++) seq_instr[i] = rom[i];
    stall_if       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    rstn           = 1'b0;

    // Reset values while rstn held low
    #12;
    check("rst.pc",    pc_out,     32'h0);
    check("rst.ipc",   ifid_pc,    32'h0);
    check("rst.ipc4",  ifid_pc4,   32'h0);
    check("rst.instr", ifid_instr, NOP);
    check("rst.valid", 32'(ifid_valid),   32'd0);
    check("rst.exc",   32'(misalign_exc), 32'd0);
    check("rst.cnt",   fetch_cnt,  32'h0);
    check("rst.imaddr", 32'(im_addr), 32'h0);

    // 1: sequential fetch, IF/ID one cycle behind pc_out
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      check_state($sformatf("seq%0d", i), 32'(4 * (i + 1)), 32'(4 * i), seq_instr[i], 1'b1, 32'(i + 1));
    end

    // 2: stall at pc_out=0x8 for two edges, then release
    do_reset();
    step();
    step();
    check_state("prestall", 32'h8, 32'h4, 32'h0030_0113, 1'b1, 32'd2);
    stall_if = 1'b1;
    step();
    step();
    check_state("stall", 32'h8, 32'h4, 32'h0030_0113, 1'b1, 32'd2);
    stall_if = 1'b0;
    step();
    check_state("unstall", 32'hC, 32'h8, 32'h0020_81B3, 1'b1, 32'd3);
    check("unstall.imaddr", 32'(im_addr), 32'h3);

    // 3: redirect with simultaneous stall at pc_out=0xC
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    stall_if       = 1'b1;
    step();
    redirect_valid = 1'b0;
    stall_if       = 1'b0;
    check_state("redir", 32'h40, 32'h8, NOP, 1'b0, 32'd3);
    check("redir.exc", 32'(misalign_exc), 32'd0);
    step();
    check_state("redir1", 32'h44, 32'h40, 32'hA500_0010, 1'b1, 32'd4);

    // 4: misaligned target -> aligned PC and a single-cycle pulse
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_002E;
    step();
    redirect_valid = 1'b0;
    check("mis.pc",  pc_out, 32'h2C);
    check("mis.exc", 32'(misalign_exc), 32'd1);
    check("mis.cnt", fetch_cnt, 32'd4);
    step();
    check("mis1.exc", 32'(misalign_exc), 32'd0);
    check_state("mis1", 32'h30, 32'h2C, 32'hA500_000B, 1'b1, 32'd5);

    // 5: last ROM word valid, first word past the ROM bubbled
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3FC;
    step();
    redirect_valid = 1'b0;
    check("oor.pc",     pc_out, 32'h3FC);
    check("oor.imaddr", 32'(im_addr), 32'hFF);
    step();
    check_state("oor0", 32'h400, 32'h3FC, 32'hA500_00FF, 1'b1, 32'd6);
    step();
    check_state("oor1", 32'h404, 32'h400, NOP, 1'b0, 32'd6);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    check("wrap.pc",   pc_out,   32'h0);
    check("wrap.ipc",  ifid_pc,  32'hFFFF_FFFC);
    check("wrap.ipc4", ifid_pc4, 32'h0);
    check("wrap.valid", 32'(ifid_valid), 32'd0);
    check("wrap.cnt",  fetch_cnt, 32'd6);

    // 6: asynchronous reset between edges at pc_out=0x20
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1C;
    step();
    redirect_valid = 1'b0;
    step();
    check_state("pre_arst", 32'h20, 32'h1C, 32'hA500_0007, 1'b1, 32'd7);
    #2;
    rstn = 1'b0;
    #1;
    check("arst.pc",    pc_out,     32'h0);
    check("arst.valid", 32'(ifid_valid), 32'd0);
    check("arst.instr", ifid_instr, NOP);
    check("arst.cnt",   fetch_cnt,  32'h0);
    check("arst.ipc",   ifid_pc,    32'h0);
    step();
    rstn = 1'b1;
    step();
    check_state("post_arst", 32'h4, 32'h0, 32'h0050_0093, 1'b1, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
